// File: rtl/bshift_pipe.sv
// Pipelined barrel shifter: SLL / SRL / SRA / ROR with a tag carried alongside each operation.
// The shift amount is resolved one binary weight (2^j) at a time; those sub-stages are spread
// across PIPE register stages, with valid/ready handshakes and full backpressure.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       synchronous active-low reset
//   in_valid_i   operation present          in_ready_o   stage 1 can accept this cycle
//   in_mode_i    00 SLL, 01 SRL, 10 SRA, 11 ROR
//   in_shamt_i   shift amount (0..WIDTH-1)  in_data_i    operand     in_tag_i   sideband tag
//   out_valid_o  result present             out_ready_i  consumer accepts result
//   out_data_o   shifted result             out_tag_o    tag of the result
//   busy_o       OR of all stage valid bits

`ifndef D_WIDTH
`define D_WIDTH 32
`endif

module bshift_pipe #(
    parameter int unsigned WIDTH   = `D_WIDTH,
    parameter int unsigned PIPE    = 2,
    parameter int unsigned TAG_W   = 5,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [1:0]         in_mode_i,
    input  logic [SHAMT_W-1:0] in_shamt_i,
    input  logic [WIDTH-1:0]   in_data_i,
    input  logic [TAG_W-1:0]   in_tag_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   out_data_o,
    output logic [TAG_W-1:0]   out_tag_o,
    output logic               busy_o
);

    localparam int P  = int'(PIPE);
    localparam int SW = int'(SHAMT_W);

    typedef enum logic [1:0] {
        ModeSll = 2'b00,
        ModeSrl = 2'b01,
        ModeSra = 2'b10,
        ModeRor = 2'b11
    } mode_e;

    // One binary sub-stage: shift by amt according to mode. SRA fills with the original operand
    // sign, which travels with the operation rather than being taken from the partial result.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input logic [1:0]       mode,
                                                    input logic             sign,
                                                    input int unsigned      amt);
        logic [2*WIDTH-1:0] ext;
        logic [2*WIDTH-1:0] ext_sh;
        logic [WIDTH-1:0]   res;
        res    = d;
        ext    = {{WIDTH{1'b0}}, d};
        unique case (mode_e'(mode))
            ModeSll: res = d << amt;
            ModeSrl: res = d >> amt;
            ModeSra: begin
                ext    = {{WIDTH{sign}}, d};
                ext_sh = ext >> amt;
                res    = ext_sh[WIDTH-1:0];
            end
            ModeRor: begin
                ext    = {d, d};
                ext_sh = ext >> amt;
                res    = ext_sh[WIDTH-1:0];
            end
            default: res = d;
        endcase
        return res;
    endfunction

    // Stage registers; index PIPE-1 drives the outputs.
    logic [PIPE-1:0]    valid_q, valid_d;
    logic [PIPE-1:0]    sign_q,  sign_d;
    logic [WIDTH-1:0]   data_q  [PIPE];
    logic [WIDTH-1:0]   data_d  [PIPE];
    logic [1:0]         mode_q  [PIPE];
    logic [1:0]         mode_d  [PIPE];
    logic [SHAMT_W-1:0] shamt_q [PIPE];
    logic [SHAMT_W-1:0] shamt_d [PIPE];
    logic [TAG_W-1:0]   tag_q   [PIPE];
    logic [TAG_W-1:0]   tag_d   [PIPE];

    // Upstream view of each stage: the input port for stage 0, the previous register otherwise.
    logic [PIPE-1:0]    src_valid;
    logic [PIPE-1:0]    src_sign;
    logic [WIDTH-1:0]   src_data  [PIPE];
    logic [1:0]         src_mode  [PIPE];
    logic [SHAMT_W-1:0] src_shamt [PIPE];
    logic [TAG_W-1:0]   src_tag   [PIPE];

    logic [PIPE-1:0]    stage_ready;

    always_comb begin
        logic             acc;
        logic             load;
        logic [WIDTH-1:0] shifted;

        // ready_k = !valid_k | ready_{k+1}: a stage is ready if it or any stage below is empty.
        acc = out_ready_i;
        for (int s = P - 1; s >= 0; s--) begin
            acc            = acc | ~valid_q[s];
            stage_ready[s] = acc;
        end

        src_valid[0] = in_valid_i;
        src_sign[0]  = in_data_i[WIDTH-1];
        src_data[0]  = in_data_i;
        src_mode[0]  = in_mode_i;
        src_shamt[0] = in_shamt_i;
        src_tag[0]   = in_tag_i;
        for (int s = 1; s < P; s++) begin
            src_valid[s] = valid_q[s-1];
            src_sign[s]  = sign_q[s-1];
            src_data[s]  = data_q[s-1];
            src_mode[s]  = mode_q[s-1];
            src_shamt[s] = shamt_q[s-1];
            src_tag[s]   = tag_q[s-1];
        end

        for (int s = 0; s < P; s++) begin
            // Amount bit j belongs in front of stage floor(j*PIPE/SHAMT_W).
            shifted = src_data[s];
            for (int j = 0; j < SW; j++) begin
                if (((j * P) / SW == s) && src_shamt[s][j]) begin
                    shifted = shift_step(shifted, src_mode[s], src_sign[s], 32'd1 << j);
                end
            end

            load       = stage_ready[s] & src_valid[s];
            valid_d[s] = stage_ready[s] ? src_valid[s] : valid_q[s];
            sign_d[s]  = load ? src_sign[s]  : sign_q[s];
            data_d[s]  = load ? shifted      : data_q[s];
            mode_d[s]  = load ? src_mode[s]  : mode_q[s];
            shamt_d[s] = load ? src_shamt[s] : shamt_q[s];
            tag_d[s]   = load ? src_tag[s]   : tag_q[s];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            sign_q  <= '0;
            for (int s = 0; s < P; s++) begin
                data_q[s]  <= '0;
                mode_q[s]  <= '0;
                shamt_q[s] <= '0;
                tag_q[s]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            sign_q  <= sign_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            shamt_q <= shamt_d;
            tag_q   <= tag_d;
        end
    end

    assign in_ready_o  = stage_ready[0];
    assign out_valid_o = valid_q[PIPE-1];
    assign out_data_o  = data_q[PIPE-1];
    assign out_tag_o   = tag_q[PIPE-1];
    assign busy_o      = |valid_q;

endmodule

// File: tb/tb_bshift_pipe.sv
// Scoreboard bench for bshift_pipe: a WIDTH=32/PIPE=2 instance with directed and random
// traffic, plus three sweep instances (32/1, 32/5, 8/3) running every mode x shift amount.
module tb_bshift_pipe;

    localparam int unsigned TAG_W = 5;
    localparam int unsigned PIPE  = 2;
    localparam logic [1:0] SLL = 2'd0, SRL = 2'd1, SRA = 2'd2, ROR = 2'd3;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: whole-word arithmetic on a w-bit operand.
    function automatic logic [31:0] ref_model(input logic [31:0] d, input logic [1:0] mode,
                                              input int sh, input int w);
        logic [63:0] mask, x, r;
        mask = (64'd1 << w) - 64'd1;
        x    = {32'd0, d} & mask;
        case (mode)
            SLL: r = x << sh;
            SRL: r = x >> sh;
            SRA: begin
                if (x[w-1]) x = x | ~mask;
                r = x >> sh;
            end
            default: r = (x >> sh) | (x << (w - sh));
        endcase
        r = r & mask;
        return r[31:0];
    endfunction

    // ---------------- main instance ----------------
    logic        rst_n, sw_rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0]  in_mode;
    logic [4:0]  in_shamt;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_tag, out_tag;

    bshift_pipe #(.WIDTH(32), .PIPE(PIPE), .TAG_W(TAG_W)) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_mode_i  (in_mode),
        .in_shamt_i (in_shamt),
        .in_data_i  (in_data),
        .in_tag_i   (in_tag),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_tag_o  (out_tag),
        .busy_o     (busy)
    );

    exp_t q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_output", 64'(out_data), 64'hDEAD_0000_0000);
            end else begin
                mon_e = q.pop_front();
                check("out_data", 64'(out_data), 64'(mon_e.data));
                check("out_tag", 64'(out_tag), 64'(mon_e.tag));
                if (mon_e.chk_lat) check("latency", 64'(cyc - mon_e.cyc), 64'(PIPE));
            end
        end
    end

    task automatic send(input logic [1:0] m, input int sh, input logic [31:0] d,
                        input logic [4:0] t, input logic [31:0] exp_d, input bit lat,
                        output int waits);
        exp_t e;
        in_valid = 1'b1;
        in_mode  = m;
        in_shamt = 5'(sh);
        in_data  = d;
        in_tag   = t;
        waits    = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (in_ready !== 1'b1) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            e.data    = exp_d;
            e.tag     = t;
            e.cyc     = cyc;
            e.chk_lat = lat;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- sweep instances ----------------
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int unsigned SWID  = (g == 2) ? 8 : 32;
        localparam int unsigned SPIPE = (g == 0) ? 1 : ((g == 1) ? 5 : 3);
        localparam int unsigned SSH   = $clog2(SWID);

        logic             s_in_valid, s_in_ready, s_out_valid, s_busy;
        logic [1:0]       s_mode;
        logic [SSH-1:0]   s_shamt;
        logic [SWID-1:0]  s_in_data, s_out_data;
        logic [TAG_W-1:0] s_in_tag, s_out_tag;
        exp_t             sq[$];
        exp_t             se;
        exp_t             me;
        bit               done = 1'b0;

        bshift_pipe #(.WIDTH(SWID), .PIPE(SPIPE), .TAG_W(TAG_W)) u_dut (
            .clk_i      (clk),
            .rst_ni     (sw_rst_n),
            .in_valid_i (s_in_valid),
            .in_ready_o (s_in_ready),
            .in_mode_i  (s_mode),
            .in_shamt_i (s_shamt),
            .in_data_i  (s_in_data),
            .in_tag_i   (s_in_tag),
            .out_valid_o(s_out_valid),
            .out_ready_i(1'b1),
            .out_data_o (s_out_data),
            .out_tag_o  (s_out_tag),
            .busy_o     (s_busy)
        );

        initial begin
            logic [31:0]      d;
            logic [TAG_W-1:0] t;
            int               n;
            s_in_valid = 1'b0;
            s_mode     = '0;
            s_shamt    = '0;
            s_in_data  = '0;
            s_in_tag   = '0;
            wait (sw_rst_n === 1'b1);
            @(posedge clk);
            #1;
            for (int m = 0; m < 4; m++) begin
                for (int sh = 0; sh < int'(SWID); sh++) begin
                    d          = $urandom;
                    t          = TAG_W'(m * 7 + sh);
                    s_in_valid = 1'b1;
                    s_mode     = 2'(m);
                    s_shamt    = SSH'(sh);
                    s_in_data  = SWID'(d);
                    s_in_tag   = t;
                    @(negedge clk);
                    check("sweep_in_ready", 64'(s_in_ready), 64'd1);
                    se.data    = ref_model(d, 2'(m), sh, int'(SWID));
                    se.tag     = t;
                    se.cyc     = cyc;
                    se.chk_lat = 1'b1;
                    sq.push_back(se);
                    @(posedge clk);
                    #1;
                end
            end
            s_in_valid = 1'b0;
            n = 0;
            while (sq.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("sweep_drain", 64'(sq.size()), 64'd0);
            done = 1'b1;
        end

        always @(negedge clk) begin
            if (sw_rst_n === 1'b1 && s_out_valid === 1'b1) begin
                if (sq.size() == 0) begin
                    check("sweep_unexpected", 64'(s_out_data), 64'hDEAD_0000_0000);
                end else begin
                    me = sq.pop_front();
                    check("sweep_data", 64'(s_out_data), 64'(me.data));
                    check("sweep_tag", 64'(s_out_tag), 64'(me.tag));
                    check("sweep_latency", 64'(cyc - me.cyc), 64'(SPIPE));
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int          w;
        int          n;
        logic [1:0]  m;
        int          sh;
        logic [31:0] d;

        rst_n     = 1'b0;
        sw_rst_n  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_mode   = '0;
        in_shamt  = '0;
        in_data   = '0;
        in_tag    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        sw_rst_n = 1'b1;

        // Directed results with latency checks.
        out_ready = 1'b1;
        send(SRA, 4, 32'h8000_0000, 5'd3, 32'hF800_0000, 1'b1, w);
        send(SRL, 4, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b1, w);
        send(SLL, 31, 32'h0000_0001, 5'd5, 32'h8000_0000, 1'b1, w);
        send(ROR, 8, 32'h1234_5678, 5'd6, 32'h7812_3456, 1'b1, w);
        send(ROR, 0, 32'h1234_5678, 5'd7, 32'h1234_5678, 1'b1, w);
        send(SRA, 4, 32'h7FFF_FFF0, 5'd8, 32'h07FF_FFFF, 1'b1, w);
        send(SLL, 0, 32'hCAFE_F00D, 5'd9, 32'hCAFE_F00D, 1'b1, w);
        drain();

        // Back-to-back random stream; in_ready must never drop.
        for (int i = 0; i < 8; i++) begin
            m  = 2'($urandom_range(0, 3));
            sh = int'($urandom_range(0, 31));
            d  = $urandom;
            send(m, sh, d, 5'(i + 16), ref_model(d, m, sh, 32), 1'b1, w);
            check("stream_in_ready", 64'(w), 64'd0);
        end
        drain();

        // Backpressure: fill, hold, then a simultaneous in/out transfer.
        out_ready = 1'b0;
        send(SRL, 4, 32'hF000_0000, 5'd10, 32'h0F00_0000, 1'b0, w);
        send(ROR, 4, 32'h0000_00FF, 5'd11, 32'hF000_000F, 1'b0, w);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_hold_data", 64'(out_data), 64'h0F00_0000);
            check("bp_hold_tag", 64'(out_tag), 64'd10);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(SLL, 2, 32'h0000_0003, 5'd12, 32'h0000_000C, 1'b0, w);
        check("bp_simultaneous", 64'(w), 64'd0);
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_next_data", 64'(out_data), 64'hF000_000F);
        check("bp_next_tag", 64'(out_tag), 64'd11);
        check("bp_still_full", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset with two operations in flight.
        out_ready = 1'b0;
        send(SLL, 1, 32'h1111_1111, 5'd13, 32'h2222_2222, 1'b0, w);
        send(SRL, 1, 32'h2222_2222, 5'd14, 32'h1111_1111, 1'b0, w);
        rst_n = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        check("mid_rst_out_tag", 64'(out_tag), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(ROR, 16, 32'hDEAD_BEEF, 5'd15, 32'hBEEF_DEAD, 1'b1, w);
        drain();

        n = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("sweep_finished",
              64'({g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}), 64'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bshift_pipe.md
Name: bshift_pipe

Overview:
- Parametrised, pipelined barrel shifter for the datapath/ALU shift unit. Supports logical left, logical right, arithmetic right and rotate right, with a shift amount from 0 to WIDTH-1.
- The shift is split into log2(WIDTH) binary stages, distributed across PIPE register stages.
- Valid/ready handshakes on both input and output, with full backpressure.
- A TAG field (destination register, thread id) travels alongside each operation.

Parameters:
WIDTH, `D_WIDTH (32), data width; power of two, >= 2
PIPE, 2, number of register stages; range 1..log2(WIDTH)
TAG_W, 5, width of sideband tag carried with each operation
SHAMT_W, log2(WIDTH), derived localparam; shift-amount width; not overridable

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input operation present
in_ready  out  1  block can accept an operation this cycle
in_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
in_shamt  in  SHAMT_W  shift amount
in_data  in  WIDTH  operand
in_tag  in  TAG_W  sideband tag
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  shifted result
out_tag  out  TAG_W  tag of the result
busy  out  1  OR of all stage valid bits

Behaviour:
- Reset: when rst_n=0 at a rising edge, all stage valid bits clear.
  - The cycle after reset: out_valid=0, busy=0, in_ready=1.
  - out_data and out_tag reset to 0; internal data registers also reset to 0.
  - Reset has priority over any handshake in the same cycle. An in-flight operation is discarded, not completed.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Stage structure: stage registers S1..S_PIPE; S_PIPE drives the out_* ports.
- Per-stage advance: ready_k = !valid_k | ready_{k+1}, with ready_{PIPE+1} = out_ready.
  - in_ready = ready_1. It is combinational from out_ready; no other combinational input-to-output paths.
  - A stage loads when it is ready and its upstream holds valid data. Otherwise it holds its contents unchanged.
  - Bubbles collapse: an empty stage always accepts.
- Shift-amount bit j (j=0..SHAMT_W-1) is applied combinationally in front of register S_k, where k = floor(j*PIPE/SHAMT_W)+1.
  - Remaining amount bits and mode travel with the data.
  - Each bit-j sub-stage shifts by 2^j according to the mode:
    - SLL: zero fill from LSB.
    - SRL: zero fill from MSB.
    - SRA: fill with the original operand MSB (carried from input, not the partial result).
    - ROR: bits shifted out of the LSB re-enter at the MSB.
- Latency: exactly PIPE cycles from input transfer to out_valid, with no stall. Throughput is one operation per cycle when out_ready=1 continuously.
- Ordering: results leave in strict input order; out_tag always matches the operation's in_tag.
- shamt=0 in any mode: out_data = in_data.
- While out_valid=1 and out_ready=0, out_data and out_tag are stable.
- Simultaneous input and output transfer on a full pipe is legal and keeps the pipe full (in_ready=1 because out_ready=1).
- Input values are don't-care when in_valid=0; no state changes from them.
- No mode reserved; all four encodings are valid.

Test Plan:
- WIDTH=32, PIPE=2: SRA 0x80000000 shamt 4 -> 0xF8000000; SRL same operand -> 0x08000000. out_valid exactly 2 cycles after accept; tags 3, 4 returned in order.
- SLL 0x00000001 shamt 31 -> 0x80000000. ROR 0x12345678 shamt 8 -> 0x78123456. ROR shamt 0 -> 0x12345678. SRA 0x7FFFFFF0 shamt 4 -> 0x07FFFFFF.
- Back-to-back stream of 8 ops with out_ready=1: one result per cycle, in_ready never drops, each result matches a reference model.
- Backpressure with out_ready=0: 2 ops fill the pipe, then in_ready=0 and out_data holds. Raising out_ready for one cycle transfers op0 and accepts a new op in the same cycle.
- Reset mid-operation: rst_n=0 for one cycle with 2 ops in flight -> next cycle out_valid=0, busy=0, out_data=0. A following op completes normally with latency 2.
- Sweep PIPE=1 and PIPE=5 at WIDTH=32, and WIDTH=8 with PIPE=3: exhaustive modes × shamt on random data. Latency equals PIPE in each case.
